// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state type, key constants and floor-mask helpers
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
    typedef struct packed {logic valid; logic [1:0] floor;} floor_sel_t;
    localparam logic [3:0] KEY_NONE = 4'b1111;
    function automatic floor_sel_t onehot_to_floor(input logic [3:0] k);
        return '{valid: k inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}, floor: {k[3] | k[2], k[3] | k[1]}};
    endfunction
    function automatic logic any_above(input logic [3:0] mask, input logic [1:0] f);
        return |(mask >> (3'(f) + 3'd1));
    endfunction
    function automatic logic any_below(input logic [3:0] mask, input logic [1:0] f);
        return |(mask & ((4'd1 << f) - 4'd1));
    endfunction
endpackage

// File: rtl/elevator_car_controller_key_debouncer.sv
// key_debouncer: registers the scanner code, waits for stability and emits one accept per press
module key_debouncer
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    output logic       accept,
    output logic [1:0] floor
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [3:0] key_q;
    logic [CW-1:0] cnt;
    logic latch, stable;
    floor_sel_t dec;
    always_comb begin
        stable = cnt == CW'(DEBOUNCE_CYCLES - 1);
        dec = onehot_to_floor(key_q);
        accept = stable && dec.valid && !latch;
        floor = dec.floor;
    end
    // counter saturates once stable so a held key keeps reporting stable without re-accepting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= KEY_NONE;
            cnt <= '0;
            latch <= 1'b0;
        end else begin
            key_q <= key_code;
            cnt <= key_code != key_q ? '0 : stable ? cnt : cnt + 1'b1;
            latch <= accept ? 1'b1 : (stable && key_q == KEY_NONE) ? 1'b0 : latch;
        end
    end
endmodule

// File: rtl/elevator_car_controller.sv
// elevator_car_controller: debounced floor requests drive a single car through move and door cycles
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int TRAVEL_CYCLES   = 50_000_000,
    parameter int DOOR_CYCLES     = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_code,
    output logic [1:0]            current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  req_ack
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    state_t state;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dcnt;
    logic acc, here, tdone, ddone;
    logic [1:0] af, nf;
    logic [3:0] abit, pm, pc;
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .accept(acc), .floor(af)
    );
    always_comb begin
        abit = acc ? 4'b0001 << af : 4'b0000;
        pm = pending | abit;
        here = acc && af == current_floor;
        tdone = tcnt == TW'(TRAVEL_CYCLES - 1);
        ddone = dcnt == DW'(DOOR_CYCLES - 1);
        nf = dir_up ? (current_floor == 2'd3 ? 2'd3 : current_floor + 2'd1)
                    : (current_floor == 2'd0 ? 2'd0 : current_floor - 2'd1);
        pc = pm & ~(4'b0001 << nf);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            current_floor <= '0;
            pending <= '0;
            moving <= 1'b0;
            dir_up <= 1'b1;
            door_open <= 1'b0;
            req_ack <= 1'b0;
            tcnt <= '0;
            dcnt <= '0;
        end else begin
            req_ack <= acc;
            case (state)
                IDLE: begin
                    if (here) begin
                        state <= DOOR;
                        door_open <= 1'b1;
                        dcnt <= '0;
                    end else begin
                        pending <= pm;
                        if (pending != '0) begin
                            state <= MOVE;
                            moving <= 1'b1;
                            tcnt <= '0;
                            dir_up <= (dir_up && any_above(pending, current_floor)) || !any_below(pending, current_floor);
                        end
                    end
                end
                MOVE: begin
                    if (tdone) begin
                        current_floor <= nf;
                        tcnt <= '0;
                        // a same-cycle request for the arrival floor is served by this stop
                        if (pm[nf]) begin
                            pending <= pc;
                            state <= DOOR;
                            moving <= 1'b0;
                            door_open <= 1'b1;
                            dcnt <= '0;
                        end else begin
                            pending <= pm;
                            dir_up <= dir_up ? any_above(pm, nf) : !any_below(pm, nf);
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        pending <= pm;
                    end
                end
                DOOR: begin
                    pending <= here ? pending : pm;
                    if (here) dcnt <= '0;
                    else if (ddone) begin
                        state <= IDLE;
                        door_open <= 1'b0;
                        dcnt <= '0;
                    end else dcnt <= dcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_car_controller.sv
// tb_elevator_car_controller: scenario and random checks against a behavioural car model
module tb_elevator_car_controller;
    localparam int D = 4, T = 8, DR = 6;
    localparam logic [9:0] RST_V = {2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic clk = 1'b0, rst_n = 1'b1;
    logic [3:0] key_code = 4'hf;
    logic [1:0] current_floor;
    logic [3:0] pending;
    logic moving, dir_up, door_open, req_ack;
    int n_run = 0, n_fail = 0;

    elevator_car_controller #(.NUM_FLOORS(4), .DEBOUNCE_CYCLES(D), .TRAVEL_CYCLES(T), .DOOR_CYCLES(DR)) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .current_floor(current_floor), .pending(pending),
        .moving(moving), .dir_up(dir_up), .door_open(door_open), .req_ack(req_ack)
    );

    always #5 clk = ~clk;

    // model: key history window for debounce, countdown timers for travel and door
    logic [3:0] hist[$];
    logic [3:0] m_pend, kv, old;
    int m_fl, m_mode, m_tleft, m_dleft, af;
    bit m_up, m_ack, m_latch, stable, acc, here;

    function automatic bit m_above(logic [3:0] m, int f);
        for (int i = f + 1; i < 4; i++) if (m[i]) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit m_below(logic [3:0] m, int f);
        for (int i = 0; i < f; i++) if (m[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {4'hf};
            m_fl = 0; m_pend = 4'h0; m_mode = 0; m_up = 1'b1; m_ack = 1'b0; m_latch = 1'b0;
            m_tleft = 0; m_dleft = 0;
        end else begin
            kv = hist[$];
            stable = hist.size() == D;
            foreach (hist[i]) if (hist[i] != kv) stable = 1'b0;
            af = -1;
            for (int i = 0; i < 4; i++) if (kv == (4'b0001 << i)) af = i;
            acc = stable && af >= 0 && !m_latch;
            if (acc) m_latch = 1'b1;
            else if (stable && kv == 4'hf) m_latch = 1'b0;
            m_ack = acc;
            here = acc && af == m_fl;
            case (m_mode)
                0: if (here) begin
                    m_mode = 2; m_dleft = DR;
                end else begin
                    old = m_pend;
                    if (acc) m_pend[af] = 1'b1;
                    if (old != 0) begin
                        m_up = (m_up && m_above(old, m_fl)) ? 1'b1 : m_below(old, m_fl) ? 1'b0 : 1'b1;
                        m_mode = 1; m_tleft = T;
                    end
                end
                1: begin
                    if (acc) m_pend[af] = 1'b1;
                    m_tleft--;
                    if (m_tleft == 0) begin
                        m_fl = m_up ? (m_fl < 3 ? m_fl + 1 : 3) : (m_fl > 0 ? m_fl - 1 : 0);
                        m_tleft = T;
                        if (m_pend[m_fl]) begin
                            m_pend[m_fl] = 1'b0; m_mode = 2; m_dleft = DR;
                        end else m_up = m_up ? m_above(m_pend, m_fl) : !m_below(m_pend, m_fl);
                    end
                end
                default: if (here) m_dleft = DR;
                else begin
                    if (acc) m_pend[af] = 1'b1;
                    m_dleft--;
                    if (m_dleft == 0) m_mode = 0;
                end
            endcase
            hist.push_back(key_code);
            if (hist.size() > D) void'(hist.pop_front());
        end
    end

    function automatic logic [9:0] dut_v();
        return {current_floor, pending, moving, dir_up, door_open, req_ack};
    endfunction
    function automatic logic [9:0] mdl_v();
        return {2'(m_fl), m_pend, m_mode == 1, m_up, m_mode == 2, m_ack};
    endfunction

    task automatic tick(input logic [3:0] k);
        key_code = k;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 n_run++;
        if (dut_v() !== RST_V) begin n_fail++; $display("FAIL reset_values got %b exp %b", dut_v(), RST_V); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_press();
        int acks = 0, door = 0, mv = 0;
        for (int c = 0; c < 60; c++) begin
            tick(c < 20 ? 4'b0100 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL single_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            acks += int'(req_ack); door += int'(door_open); mv += int'(moving);
        end
        n_run += 5;
        if (acks !== 1) begin n_fail++; $display("FAIL single_acks got %0d exp 1", acks); end
        if (mv !== 2 * T) begin n_fail++; $display("FAIL single_move_cycles got %0d exp %0d", mv, 2 * T); end
        if (door !== DR) begin n_fail++; $display("FAIL single_door_cycles got %0d exp %0d", door, DR); end
        if (current_floor !== 2'd2) begin n_fail++; $display("FAIL single_floor got %0d exp 2", current_floor); end
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending got %b exp 0000", pending); end
    endtask

    task automatic test_bounce();
        int acks = 0;
        logic [3:0] pmax = 4'h0;
        for (int c = 0; c < 26; c++) begin
            tick(c < 20 && (c / 2) % 2 == 0 ? 4'b0010 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL bounce_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            acks += int'(req_ack); pmax |= pending;
        end
        n_run += 2;
        if (acks !== 0) begin n_fail++; $display("FAIL bounce_acks got %0d exp 0", acks); end
        if (pmax !== 4'h0) begin n_fail++; $display("FAIL bounce_pending got %b exp 0000", pmax); end
    endtask

    task automatic test_door_reload();
        int door = 0, rl = 0;
        bit counting = 1'b0;
        logic [3:0] pmax = 4'h0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick(c < 6 ? 4'b0001 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL samefloor_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            door += int'(door_open); pmax |= pending;
        end
        n_run += 2;
        if (door !== DR) begin n_fail++; $display("FAIL samefloor_door got %0d exp %0d", door, DR); end
        if (pmax !== 4'h0) begin n_fail++; $display("FAIL samefloor_pending got %b exp 0000", pmax); end
        door = 0;
        for (int c = 0; c < 37; c++) begin
            tick(c < 5 || (c >= 11 && c < 17) ? 4'b0010 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL reload_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            if (req_ack && door_open) begin counting = 1'b1; rl = 0; end
            if (counting) rl += int'(door_open);
            door += int'(door_open);
        end
        n_run += 2;
        if (rl !== DR) begin n_fail++; $display("FAIL reload_door_after_reload got %0d exp %0d", rl, DR); end
        if (door !== DR + 2) begin n_fail++; $display("FAIL reload_door_total got %0d exp %0d", door, DR + 2); end
    endtask

    task automatic test_reverse();
        int doors[$];
        bit prev = 1'b0, done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick(c < 5 ? 4'b1000 : (c >= 11 && c < 17) ? 4'b0001 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL reverse_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            if (door_open && !prev) doors.push_back(int'(current_floor));
            prev = door_open;
            done = c > 17 && m_mode == 0 && m_pend == 0;
        end
        n_run += 4;
        if (!done) begin n_fail++; $display("FAIL reverse_timeout got busy exp idle"); end
        if (doors.size() !== 2 || doors[0] !== 3 || doors[1] !== 0) begin
            n_fail++; $display("FAIL reverse_order got %p exp '{3,0}", doors);
        end
        if (dir_up !== 1'b0) begin n_fail++; $display("FAIL reverse_dir got %b exp 0", dir_up); end
        if (current_floor !== 2'd0) begin n_fail++; $display("FAIL reverse_floor got %0d exp 0", current_floor); end
    endtask

    task automatic test_invalid();
        int early = 0, acks = 0;
        bit done = 1'b0;
        for (int c = 0; c < 120 && !done; c++) begin
            tick(c < 8 ? 4'b0110 : c < 16 ? 4'b0000 : c < 22 ? 4'b0100 : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL invalid_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            if (c < 16) early += int'(req_ack);
            acks += int'(req_ack);
            done = c > 22 && m_mode == 0 && m_pend == 0;
        end
        n_run += 3;
        if (early !== 0) begin n_fail++; $display("FAIL invalid_acks got %0d exp 0", early); end
        if (acks !== 1) begin n_fail++; $display("FAIL invalid_then_valid_acks got %0d exp 1", acks); end
        if (current_floor !== 2'd2) begin n_fail++; $display("FAIL invalid_then_valid_floor got %0d exp 2", current_floor); end
    endtask

    task automatic test_random();
        logic [3:0] keys[9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'hf, 4'hf, 4'b0110, 4'b0000, 4'b0011};
        logic [3:0] k;
        bit done = 1'b0;
        for (int s = 0; s < 60; s++) begin
            k = keys[$urandom_range(0, 8)];
            repeat ($urandom_range(1, 10)) begin
                tick(k);
                n_run++;
                if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL random_lockstep s=%0d got %b exp %b", s, dut_v(), mdl_v()); end
            end
        end
        for (int c = 0; c < 400 && !done; c++) begin
            tick(4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL random_drain c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
            done = c > D && m_mode == 0 && m_pend == 0;
        end
        n_run++;
        if (!done) begin n_fail++; $display("FAIL random_timeout got busy exp idle"); end
    endtask

    task automatic test_reset_mid_move();
        logic [3:0] k;
        k = 4'b0001 << ((current_floor + 2'd2) % 4);
        for (int c = 0; c < 13; c++) begin
            tick(c < 5 ? k : 4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL midmove_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
        end
        n_run += 2;
        if (moving !== 1'b1) begin n_fail++; $display("FAIL midmove_moving got %b exp 1", moving); end
        #2 rst_n = 1'b0;
        #1 if (dut_v() !== RST_V) begin n_fail++; $display("FAIL midmove_reset got %b exp %b", dut_v(), RST_V); end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(4'hf);
            n_run++;
            if (dut_v() !== mdl_v()) begin n_fail++; $display("FAIL postreset_lockstep c=%0d got %b exp %b", c, dut_v(), mdl_v()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_door_reload();
        test_reverse();
        test_invalid();
        test_random();
        test_reset_mid_move();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
